// File: rtl/if_id_queue_if.sv
// Handshake and bundle signals between fetch, the IF/ID queue and decode.
// The queue takes the slave modport. The fetch/decode side (or a bench) takes the master modport.
interface if_id_queue_if #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned ADDR_W  = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic               FLUSH;
  logic               IF_VALID;
  logic               IF_READY;
  logic [INSTR_W-1:0] Instr_IN;
  logic [ADDR_W-1:0]  Instr_PC_IN;
  logic [ADDR_W-1:0]  Instr_PC_Plus4_IN;
  logic               Branch_prediction_IN;
  logic [ADDR_W-1:0]  Branch_prediction_addr_IN;
  logic [1:0]         Branch_predictions_IN;

  logic               ID_READY;
  logic               OUT_VALID;
  logic [INSTR_W-1:0] Instr_OUT;
  logic [ADDR_W-1:0]  Instr_PC_OUT;
  logic [ADDR_W-1:0]  Instr_PC_Plus4_OUT;
  logic               Branch_prediction_OUT;
  logic [ADDR_W-1:0]  Branch_prediction_addr_OUT;
  logic [1:0]         Branch_predictions_OUT;
  logic [CNT_W-1:0]   COUNT;

  modport slave (
    input  FLUSH, IF_VALID, Instr_IN, Instr_PC_IN, Instr_PC_Plus4_IN,
           Branch_prediction_IN, Branch_prediction_addr_IN, Branch_predictions_IN,
           ID_READY,
    output IF_READY, OUT_VALID, Instr_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT,
           Branch_prediction_OUT, Branch_prediction_addr_OUT, Branch_predictions_OUT,
           COUNT
  );

  modport master (
    output FLUSH, IF_VALID, Instr_IN, Instr_PC_IN, Instr_PC_Plus4_IN,
           Branch_prediction_IN, Branch_prediction_addr_IN, Branch_predictions_IN,
           ID_READY,
    input  IF_READY, OUT_VALID, Instr_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT,
           Branch_prediction_OUT, Branch_prediction_addr_OUT, Branch_predictions_OUT,
           COUNT
  );
endinterface

// File: rtl/if_id_queue.sv
// DEPTH-entry FIFO of fetch bundles between IF and ID, with a valid/ready handshake on each side.
// A synchronous flush empties the queue in one cycle for mispredict recovery.
module if_id_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  if_id_queue_if.slave    bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus4;
    logic               bp_taken;
    logic [ADDR_W-1:0]  bp_addr;
    logic [1:0]         bp_state;
  } bundle_t;

  bundle_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic    full_c, empty_c, wr_fire_c, rd_fire_c, we_c;
  bundle_t wdata_c, head_c;

  // Ready and valid depend only on the occupancy count, so there is no combinational path from ID_READY to IF_READY.
  always_comb begin
    full_c    = (cnt_q == CNT_W'(DEPTH));
    empty_c   = (cnt_q == CNT_W'(0));
    wr_fire_c = bus.IF_VALID && !full_c;
    rd_fire_c = !empty_c && bus.ID_READY;
    we_c      = wr_fire_c && !bus.FLUSH;
  end

  always_comb begin
    wdata_c          = '0;
    wdata_c.instr    = bus.Instr_IN;
    wdata_c.pc       = bus.Instr_PC_IN;
    wdata_c.pc_plus4 = bus.Instr_PC_Plus4_IN;
    wdata_c.bp_taken = bus.Branch_prediction_IN;
    wdata_c.bp_addr  = bus.Branch_prediction_addr_IN;
    wdata_c.bp_state = bus.Branch_predictions_IN;
  end

  // Flush overrides push and pop. Both pointers wrap naturally because DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (bus.FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_fire_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_fire_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (wr_fire_c && !rd_fire_c)      cnt_d = cnt_q + CNT_W'(1);
      else if (!wr_fire_c && rd_fire_c) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset. Stale entries are never visible because the head is masked while the queue is empty.
  always_ff @(posedge CLK) begin
    if (we_c) mem_q[wr_ptr_q] <= wdata_c;
  end

  // An empty queue presents an all-zero bundle, so ID sees a NOP bubble.
  always_comb begin
    head_c = '0;
    if (!empty_c) head_c = mem_q[rd_ptr_q];
  end

  assign bus.IF_READY                   = !full_c;
  assign bus.OUT_VALID                  = !empty_c;
  assign bus.COUNT                      = cnt_q;
  assign bus.Instr_OUT                  = head_c.instr;
  assign bus.Instr_PC_OUT               = head_c.pc;
  assign bus.Instr_PC_Plus4_OUT         = head_c.pc_plus4;
  assign bus.Branch_prediction_OUT      = head_c.bp_taken;
  assign bus.Branch_prediction_addr_OUT = head_c.bp_addr;
  assign bus.Branch_predictions_OUT     = head_c.bp_state;
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue. Each step drives the queue and then checks it against hand-computed values.
module tb_if_id_queue;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pc_new;

  always #5 CLK = ~CLK;

  if_id_queue_if #(.DEPTH(4), .INSTR_W(32), .ADDR_W(32)) bus ();

  if_id_queue #(.DEPTH(4), .INSTR_W(32), .ADDR_W(32)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
    bus.IF_VALID                  = v;
    bus.Instr_IN                  = 32'hA000_0000 | pc;
    bus.Instr_PC_IN               = pc;
    bus.Instr_PC_Plus4_IN         = pc + 32'd4;
    bus.Branch_prediction_IN      = 1'b0;
    bus.Branch_prediction_addr_IN = 32'h0;
    bus.Branch_predictions_IN     = 2'b00;
    bus.ID_READY                  = rdy;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bus.FLUSH = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    #12;
    chk("rst_if_ready", 64'(bus.IF_READY), 64'd1);
    chk("rst_out_valid", 64'(bus.OUT_VALID), 64'd0);
    chk("rst_count", 64'(bus.COUNT), 64'd0);
    chk("rst_instr", 64'(bus.Instr_OUT), 64'd0);
    chk("rst_pc", 64'(bus.Instr_PC_OUT), 64'd0);
    @(negedge CLK);
    RESET = 1'b1;

    // Three pushes with decode stalled.
    drive(1'b1, 32'h100, 1'b0);
    tick();
    chk("lat_out_valid", 64'(bus.OUT_VALID), 64'd1);
    chk("lat_pc", 64'(bus.Instr_PC_OUT), 64'h100);
    drive(1'b1, 32'h104, 1'b0);
    tick();
    drive(1'b1, 32'h108, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("p3_count", 64'(bus.COUNT), 64'd3);
    chk("p3_head_pc", 64'(bus.Instr_PC_OUT), 64'h100);
    chk("p3_head_instr", 64'(bus.Instr_OUT), 64'hA000_0100);
    chk("p3_plus4", 64'(bus.Instr_PC_Plus4_OUT), 64'h104);

    // Fill to DEPTH. The next push is refused, even with a pop in the same cycle.
    drive(1'b1, 32'h10C, 1'b0);
    tick();
    chk("full_count", 64'(bus.COUNT), 64'd4);
    chk("full_if_ready", 64'(bus.IF_READY), 64'd0);
    drive(1'b1, 32'h110, 1'b0);
    tick();
    chk("full_hold_count", 64'(bus.COUNT), 64'd4);
    chk("full_hold_head", 64'(bus.Instr_PC_OUT), 64'h100);
    drive(1'b1, 32'h110, 1'b1);
    tick();
    chk("pop_count", 64'(bus.COUNT), 64'd3);
    chk("pop_if_ready", 64'(bus.IF_READY), 64'd1);
    chk("pop_head", 64'(bus.Instr_PC_OUT), 64'h104);

    // Pop down to two entries, then run push+pop together across pointer wraps.
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("two_count", 64'(bus.COUNT), 64'd2);
    exp_q = '{32'h108, 32'h10C};
    for (int i = 0; i < 10; i++) begin
      pc_new = 32'h300 + 32'(4 * i);
      chk($sformatf("stream_head_%0d", i), 64'(bus.Instr_PC_OUT), 64'(exp_q[0]));
      drive(1'b1, pc_new, 1'b1);
      exp_q.push_back(pc_new);
      void'(exp_q.pop_front());
      tick();
      chk($sformatf("stream_count_%0d", i), 64'(bus.COUNT), 64'd2);
    end
    drive(1'b0, 32'h0, 1'b0);
    chk("stream_tail_head", 64'(bus.Instr_PC_OUT), 64'h320);

    // Flush at three entries drops the incoming bundle too.
    drive(1'b1, 32'h400, 1'b0);
    tick();
    chk("pre_flush_count", 64'(bus.COUNT), 64'd3);
    drive(1'b1, 32'h404, 1'b1);
    bus.FLUSH = 1'b1;
    tick();
    bus.FLUSH = 1'b0;
    chk("flush_count", 64'(bus.COUNT), 64'd0);
    chk("flush_out_valid", 64'(bus.OUT_VALID), 64'd0);
    chk("flush_instr", 64'(bus.Instr_OUT), 64'd0);
    // A push into an empty queue with ID_READY=1 does not pop in the same cycle.
    drive(1'b1, 32'h500, 1'b1);
    tick();
    chk("post_flush_count", 64'(bus.COUNT), 64'd1);
    chk("post_flush_head", 64'(bus.Instr_PC_OUT), 64'h500);
    chk("post_flush_valid", 64'(bus.OUT_VALID), 64'd1);

    // Branch prediction fields travel through the queue.
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("drain_count", 64'(bus.COUNT), 64'd0);
    drive(1'b1, 32'h600, 1'b0);
    bus.Branch_prediction_IN      = 1'b1;
    bus.Branch_prediction_addr_IN = 32'h200;
    bus.Branch_predictions_IN     = 2'b11;
    tick();
    chk("bp_pc", 64'(bus.Instr_PC_OUT), 64'h600);
    chk("bp_plus4", 64'(bus.Instr_PC_Plus4_OUT), 64'h604);
    chk("bp_taken", 64'(bus.Branch_prediction_OUT), 64'd1);
    chk("bp_addr", 64'(bus.Branch_prediction_addr_OUT), 64'h200);
    chk("bp_state", 64'(bus.Branch_predictions_OUT), 64'd3);
    chk("bp_instr", 64'(bus.Instr_OUT), 64'hA000_0600);

    // Asynchronous reset mid-stream with two entries.
    drive(1'b1, 32'h604, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("pre_rst_count", 64'(bus.COUNT), 64'd2);
    #2;
    RESET = 1'b0;
    #1;
    chk("arst_count", 64'(bus.COUNT), 64'd0);
    chk("arst_out_valid", 64'(bus.OUT_VALID), 64'd0);
    chk("arst_if_ready", 64'(bus.IF_READY), 64'd1);
    chk("arst_instr", 64'(bus.Instr_OUT), 64'd0);
    chk("arst_bp", 64'(bus.Branch_prediction_OUT), 64'd0);
    @(negedge CLK);
    RESET = 1'b1;
    drive(1'b1, 32'h700, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("post_rst_head", 64'(bus.Instr_PC_OUT), 64'h700);
    chk("post_rst_count", 64'(bus.COUNT), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
